decode_1: RTL and testbench

- First decode stage of the core pipeline. Accepts fetched instructions from the fetch unit over a valid/ready handshake and buffers them in a small FIFO.
- Extracts the fixed RV32I fields and all five immediate formats, presenting them registered on the DECODE1_* interface consumed by decode_2.
- Absorbs fetch/decode rate mismatch; supports pipeline stall and flush.

---
 rtl/decode_1_if.sv | 39 +++
 rtl/decode_1.sv | 163 ++++++++++++++++
 tb/tb_decode_1.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_1_if.sv
// Fetch-to-decode handshake plus the registered DECODE1_* field bundle.
// master = fetch/consumer side, slave = the decode_1 stage.
interface decode_1_if;
  logic        FETCH_VALID;
  logic [31:0] FETCH_PC;
  logic [31:0] FETCH_INST;
  logic        FETCH_READY;

  logic        DECODE1_VALID;
  logic [31:0] DECODE1_PC;
  logic [6:0]  DECODE1_OPCODE;
  logic [4:0]  DECODE1_RD;
  logic [4:0]  DECODE1_RS1;
  logic [4:0]  DECODE1_RS2;
  logic [2:0]  DECODE1_FUNCT3;
  logic [6:0]  DECODE1_FUNCT7;
  logic [31:0] DECODE1_IMM_I;
  logic [31:0] DECODE1_IMM_S;
  logic [31:0] DECODE1_IMM_B;
  logic [31:0] DECODE1_IMM_U;
  logic [31:0] DECODE1_IMM_J;
  logic        DECODE1_ILLEGAL;

  modport master (
    output FETCH_VALID, FETCH_PC, FETCH_INST,
    input  FETCH_READY,
    input  DECODE1_VALID, DECODE1_PC, DECODE1_OPCODE, DECODE1_RD, DECODE1_RS1, DECODE1_RS2,
    input  DECODE1_FUNCT3, DECODE1_FUNCT7, DECODE1_IMM_I, DECODE1_IMM_S, DECODE1_IMM_B,
    input  DECODE1_IMM_U, DECODE1_IMM_J, DECODE1_ILLEGAL
  );

  modport slave (
    input  FETCH_VALID, FETCH_PC, FETCH_INST,
    output FETCH_READY,
    output DECODE1_VALID, DECODE1_PC, DECODE1_OPCODE, DECODE1_RD, DECODE1_RS1, DECODE1_RS2,
    output DECODE1_FUNCT3, DECODE1_FUNCT7, DECODE1_IMM_I, DECODE1_IMM_S, DECODE1_IMM_B,
    output DECODE1_IMM_U, DECODE1_IMM_J, DECODE1_ILLEGAL
  );
endinterface

// File: rtl/decode_1.sv
// First decode stage: instruction FIFO plus registered RV32I field/immediate extraction.
// Optional macro DECODE1_ILLEGAL_FILTER_EN drops non-32-bit encodings and pulses DECODE1_ILLEGAL.
module decode_1 #(
  parameter int unsigned DEPTH = 4
) (
  input logic       CLK,
  input logic       RST,
  input logic       FLUSH,
  input logic       STALL,
  decode_1_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PtrW:0] ptr_t;
  localparam ptr_t Full = ptr_t'(DEPTH);

  ptr_t        wr_ptr;
  ptr_t        rd_ptr;
  ptr_t        count;
  logic [63:0] mem [DEPTH];

  logic        fetch_ready;
  logic        push;
  logic        pop;
  logic        head_ok;
  logic [31:0] head_pc;
  logic [31:0] head_inst;

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic        d1_valid;
  logic [31:0] d1_pc;
  logic [6:0]  d1_opcode;
  logic [4:0]  d1_rd;
  logic [4:0]  d1_rs1;
  logic [4:0]  d1_rs2;
  logic [2:0]  d1_funct3;
  logic [6:0]  d1_funct7;
  logic [31:0] d1_imm_i;
  logic [31:0] d1_imm_s;
  logic [31:0] d1_imm_b;
  logic [31:0] d1_imm_u;
  logic [31:0] d1_imm_j;

  // Extra pointer bit makes wr - rd span 0..DEPTH without a separate count register.
  assign count       = wr_ptr - rd_ptr;
  assign fetch_ready = (count != Full);
  assign push        = bus.FETCH_VALID && fetch_ready && !FLUSH;
  assign pop         = !STALL && !FLUSH && (count != '0);

  assign {head_pc, head_inst} = mem[rd_ptr[PtrW-1:0]];

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr[PtrW-1:0]] <= {bus.FETCH_PC, bus.FETCH_INST};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
    end
  end

  always_comb begin
    imm_i = {{20{head_inst[31]}}, head_inst[31:20]};
    imm_s = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
    imm_b = {{19{head_inst[31]}}, head_inst[31], head_inst[7], head_inst[30:25],
             head_inst[11:8], 1'b0};
    imm_u = {head_inst[31:12], 12'b0};
    imm_j = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12], head_inst[20],
             head_inst[30:21], 1'b0};
  end

`ifdef DECODE1_ILLEGAL_FILTER_EN
  logic illegal_q;

  assign head_ok = (head_inst[1:0] == 2'b11);

  // Strict one-cycle pulse: cleared on every edge that does not pop a bad entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= pop && !head_ok;
    end
  end

  assign bus.DECODE1_ILLEGAL = illegal_q;
`else
  assign head_ok             = 1'b1;
  assign bus.DECODE1_ILLEGAL = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      d1_valid  <= 1'b0;
      d1_pc     <= '0;
      d1_opcode <= '0;
      d1_rd     <= '0;
      d1_rs1    <= '0;
      d1_rs2    <= '0;
      d1_funct3 <= '0;
      d1_funct7 <= '0;
      d1_imm_i  <= '0;
      d1_imm_s  <= '0;
      d1_imm_b  <= '0;
      d1_imm_u  <= '0;
      d1_imm_j  <= '0;
    end else if (FLUSH) begin
      d1_valid <= 1'b0;
    end else if (!STALL) begin
      if (pop) begin
        d1_valid  <= head_ok;
        d1_pc     <= head_pc;
        d1_opcode <= head_inst[6:0];
        d1_rd     <= head_inst[11:7];
        d1_rs1    <= head_inst[19:15];
        d1_rs2    <= head_inst[24:20];
        d1_funct3 <= head_inst[14:12];
        d1_funct7 <= head_inst[31:25];
        d1_imm_i  <= imm_i;
        d1_imm_s  <= imm_s;
        d1_imm_b  <= imm_b;
        d1_imm_u  <= imm_u;
        d1_imm_j  <= imm_j;
      end else begin
        d1_valid <= 1'b0;
      end
    end
  end

  assign bus.FETCH_READY    = fetch_ready;
  assign bus.DECODE1_VALID  = d1_valid;
  assign bus.DECODE1_PC     = d1_pc;
  assign bus.DECODE1_OPCODE = d1_opcode;
  assign bus.DECODE1_RD     = d1_rd;
  assign bus.DECODE1_RS1    = d1_rs1;
  assign bus.DECODE1_RS2    = d1_rs2;
  assign bus.DECODE1_FUNCT3 = d1_funct3;
  assign bus.DECODE1_FUNCT7 = d1_funct7;
  assign bus.DECODE1_IMM_I  = d1_imm_i;
  assign bus.DECODE1_IMM_S  = d1_imm_s;
  assign bus.DECODE1_IMM_B  = d1_imm_b;
  assign bus.DECODE1_IMM_U  = d1_imm_u;
  assign bus.DECODE1_IMM_J  = d1_imm_j;

endmodule

// File: tb/tb_decode_1.sv
// Directed bench for decode_1: field table, stall/backpressure, flush, async reset, illegal filter.
module tb_decode_1;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic stall;

  always #5 clk = ~clk;

  decode_1_if bus ();

  decode_1 #(.DEPTH(4)) dut (
    .CLK  (clk),
    .RST  (rst),
    .FLUSH(flush),
    .STALL(stall),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] ii;
    logic [31:0] is;
    logic [31:0] ib;
    logic [31:0] iu;
    logic [31:0] ij;
  } vec_t;

  vec_t vecs [5];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input vec_t v, input string tag);
    chk({tag, ".valid"},  32'(bus.DECODE1_VALID),  32'd1);
    chk({tag, ".pc"},     bus.DECODE1_PC,          v.pc);
    chk({tag, ".opcode"}, 32'(bus.DECODE1_OPCODE), 32'(v.opcode));
    chk({tag, ".rd"},     32'(bus.DECODE1_RD),     32'(v.rd));
    chk({tag, ".rs1"},    32'(bus.DECODE1_RS1),    32'(v.rs1));
    chk({tag, ".rs2"},    32'(bus.DECODE1_RS2),    32'(v.rs2));
    chk({tag, ".funct3"}, 32'(bus.DECODE1_FUNCT3), 32'(v.f3));
    chk({tag, ".funct7"}, 32'(bus.DECODE1_FUNCT7), 32'(v.f7));
    chk({tag, ".imm_i"},  bus.DECODE1_IMM_I,       v.ii);
    chk({tag, ".imm_s"},  bus.DECODE1_IMM_S,       v.is);
    chk({tag, ".imm_b"},  bus.DECODE1_IMM_B,       v.ib);
    chk({tag, ".imm_u"},  bus.DECODE1_IMM_U,       v.iu);
    chk({tag, ".imm_j"},  bus.DECODE1_IMM_J,       v.ij);
  endtask

  task automatic push_word(input logic [31:0] pc, input logic [31:0] inst);
    bus.FETCH_VALID = 1'b1;
    bus.FETCH_PC    = pc;
    bus.FETCH_INST  = inst;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected fields hand-decoded from each instruction word.
    vecs[0] = '{32'h0000_0000, 32'h0050_0093, 7'h13, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00,
                32'h0000_0005, 32'h0000_0001, 32'h0000_0800, 32'h0050_0000, 32'h0000_0804};
    vecs[1] = '{32'h0000_0004, 32'h0020_A423, 7'h23, 5'd8, 5'd1, 5'd2, 3'd2, 7'h00,
                32'h0000_0002, 32'h0000_0008, 32'h0000_0008, 32'h0020_A000, 32'h0000_A002};
    vecs[2] = '{32'h0000_0008, 32'hFE00_0EE3, 7'h63, 5'd29, 5'd0, 5'd0, 3'd0, 7'h7F,
                32'hFFFF_FFE0, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'hFE00_0000, 32'hFFF0_07E0};
    vecs[3] = '{32'h0000_000C, 32'h1234_52B7, 7'h37, 5'd5, 5'd8, 5'd3, 3'd5, 7'h09,
                32'h0000_0123, 32'h0000_0125, 32'h0000_0924, 32'h1234_5000, 32'h0004_5922};
    vecs[4] = '{32'h0000_0010, 32'h8000_00EF, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h40,
                32'hFFFF_F800, 32'hFFFF_F801, 32'hFFFF_F800, 32'h8000_0000, 32'hFFF0_0000};

    rst   = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    bus.FETCH_VALID = 1'b0;
    bus.FETCH_PC    = '0;
    bus.FETCH_INST  = '0;

    // Reset state before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst.valid",   32'(bus.DECODE1_VALID),   32'd0);
    chk("rst.ready",   32'(bus.FETCH_READY),     32'd1);
    chk("rst.pc",      bus.DECODE1_PC,           32'd0);
    chk("rst.opcode",  32'(bus.DECODE1_OPCODE),  32'd0);
    chk("rst.imm_j",   bus.DECODE1_IMM_J,        32'd0);
    chk("rst.illegal", 32'(bus.DECODE1_ILLEGAL), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Back-to-back stream: each word emerges one edge after it is pushed.
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) push_word(vecs[i].pc, vecs[i].inst);
      else bus.FETCH_VALID = 1'b0;
      tick();
      if (i == 0) chk("lat.valid0", 32'(bus.DECODE1_VALID), 32'd0);
      else chk_vec(vecs[i-1], $sformatf("vec%0d", i - 1));
      chk($sformatf("stream.ready%0d", i), 32'(bus.FETCH_READY), 32'd1);
    end

    // Stall with vecs[4] on the outputs: fill the FIFO, fifth word must wait.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_word(32'h200 + 32'(4 * i), 32'h0000_0013 | (32'(i) << 20));
      tick();
      if (i >= 3) chk($sformatf("stall.ready%0d", i), 32'(bus.FETCH_READY), 32'd0);
    end
    chk("stall.hold_valid", 32'(bus.DECODE1_VALID), 32'd1);
    chk("stall.hold_pc",    bus.DECODE1_PC,         vecs[4].pc);
    chk("stall.hold_imm_u", bus.DECODE1_IMM_U,      vecs[4].iu);

    stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) chk("unstall.ready", 32'(bus.FETCH_READY), 32'd1);
      if (k == 1) bus.FETCH_VALID = 1'b0;
      chk($sformatf("drain%0d.valid", k), 32'(bus.DECODE1_VALID), 32'd1);
      chk($sformatf("drain%0d.pc", k),    bus.DECODE1_PC,         32'h200 + 32'(4 * k));
      chk($sformatf("drain%0d.imm_i", k), bus.DECODE1_IMM_I,      32'(k));
    end
    tick();
    chk("drain.empty", 32'(bus.DECODE1_VALID), 32'd0);

    // Flush with three queued and a same-cycle fetch.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_word(32'h300 + 32'(4 * i), vecs[1].inst);
      tick();
    end
    flush = 1'b1;
    stall = 1'b0;
    push_word(32'h3F0, vecs[2].inst);
    tick();
    flush = 1'b0;
    bus.FETCH_VALID = 1'b0;
    chk("flush.valid", 32'(bus.DECODE1_VALID), 32'd0);
    chk("flush.ready", 32'(bus.FETCH_READY),   32'd1);
    tick();
    chk("flush.empty", 32'(bus.DECODE1_VALID), 32'd0);
    push_word(32'h400, vecs[0].inst);
    tick();
    bus.FETCH_VALID = 1'b0;
    chk("postflush.lat", 32'(bus.DECODE1_VALID), 32'd0);
    tick();
    chk("postflush.valid",  32'(bus.DECODE1_VALID),  32'd1);
    chk("postflush.pc",     bus.DECODE1_PC,          32'h400);
    chk("postflush.opcode", 32'(bus.DECODE1_OPCODE), 32'h13);
    tick();
    chk("postflush.empty", 32'(bus.DECODE1_VALID), 32'd0);

    // Async reset mid-stream with two entries queued.
    push_word(32'h500, vecs[1].inst);
    tick();
    push_word(32'h504, vecs[2].inst);
    tick();
    stall = 1'b1;
    push_word(32'h508, vecs[3].inst);
    tick();
    bus.FETCH_VALID = 1'b0;
    chk("prerst.valid", 32'(bus.DECODE1_VALID), 32'd1);
    chk("prerst.pc",    bus.DECODE1_PC,         32'h500);
    #2 rst = 1'b1;
    #1;
    chk("arst.valid",  32'(bus.DECODE1_VALID),  32'd0);
    chk("arst.pc",     bus.DECODE1_PC,          32'd0);
    chk("arst.opcode", 32'(bus.DECODE1_OPCODE), 32'd0);
    chk("arst.imm_s",  bus.DECODE1_IMM_S,       32'd0);
    chk("arst.ready",  32'(bus.FETCH_READY),    32'd1);
    tick();
    rst   = 1'b0;
    stall = 1'b0;
    tick();
    chk("arst.nostale0", 32'(bus.DECODE1_VALID), 32'd0);
    tick();
    chk("arst.nostale1", 32'(bus.DECODE1_VALID), 32'd0);

    // Compressed encoding at PC 0x100.
    push_word(32'h100, 32'h0000_4501);
    tick();
    bus.FETCH_VALID = 1'b0;
    tick();
`ifdef DECODE1_ILLEGAL_FILTER_EN
    chk("rvc.valid",   32'(bus.DECODE1_VALID),   32'd0);
    chk("rvc.illegal", 32'(bus.DECODE1_ILLEGAL), 32'd1);
`else
    chk("rvc.valid",   32'(bus.DECODE1_VALID),   32'd1);
    chk("rvc.illegal", 32'(bus.DECODE1_ILLEGAL), 32'd0);
`endif
    chk("rvc.pc", bus.DECODE1_PC, 32'h100);
    tick();
    chk("rvc.pulse_end", 32'(bus.DECODE1_ILLEGAL), 32'd0);
    chk("rvc.empty",     32'(bus.DECODE1_VALID),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
